// File: rtl/knight_fade.sv
// knight_fade: eight-LED flasher; each LED snaps to full brightness when its pattern bit is set,
// then fades linearly to off and is driven through a shared PWM. Define KNIGHT_FADE_GAMMA_EN for a square-law duty curve.
module knight_fade #(
  parameter int PWM_BITS  = 4,
  parameter int DECAY_DIV = 1024
) (
  input  logic       ck,
  input  logic       res,
  input  logic [7:0] in,
  output logic [7:0] led
);

  localparam logic [PWM_BITS-1:0] MAX   = '1;
  localparam int                  DW    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0]       DLAST = DW'(DECAY_DIV - 1);

  logic [DW-1:0]       dcnt;
  logic [PWM_BITS-1:0] pcnt;
  logic [PWM_BITS-1:0] bright [8];
  logic                tick;

  // One decay step that sticks at zero instead of wrapping.
  function automatic logic [PWM_BITS-1:0] dec_sat(input logic [PWM_BITS-1:0] b);
    return (b == '0) ? b : b - PWM_BITS'(1);
  endfunction

  function automatic logic [PWM_BITS-1:0] to_cmp(input logic [PWM_BITS-1:0] b);
`ifdef KNIGHT_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return b;
`endif
  endfunction

  assign tick = (dcnt == DLAST);

  // Stage 1: brightness registers; Stage 2: PWM compare into the led register.
  always_ff @(posedge ck) begin
    if (!res) begin
      dcnt <= '0;
      pcnt <= '0;
      led  <= '0;
      for (int i = 0; i < 8; i++) bright[i] <= '0;
    end else begin
      dcnt <= tick ? '0 : dcnt + DW'(1);
      pcnt <= pcnt + PWM_BITS'(1);
      for (int i = 0; i < 8; i++) begin
        led[i] <= (bright[i] == MAX) || (pcnt < to_cmp(bright[i]));
        if (in[i])
          bright[i] <= MAX;
        else if (tick)
          bright[i] <= dec_sat(bright[i]);
      end
    end
  end

endmodule
